// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Pure declarations; no timing or flow control of its own.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_res_t;

  // Frame bits are column-major (col*4 + row); key codes are row*4 + col.
  function automatic logic [CODE_W-1:0] bit_to_code(input logic [3:0] idx);
    return {idx[1:0], idx[3:2]};
  endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column driver and frame capture: walks one low column per SCAN_DIV cycles, samples rows.
// Rows see 2 cycles of sync latency; frame_done/frame_bits valid on the last cycle of column 3; never stalls.
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_ROWS-1:0]           row_in,
  output logic [NUM_COLS-1:0]           col_out,
  output logic                          frame_done,
  output logic [NUM_ROWS*NUM_COLS-1:0]  frame_bits
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]    div;
  logic [1:0]          col;
  logic [NUM_ROWS-1:0] row_s1;
  logic [NUM_ROWS-1:0] row_s2;
  logic [11:0]         frame_q;
  logic                step;

  assign step       = (div == DIV_LAST);
  assign frame_done = step && (col == 2'd3);
  // Column 3 is presented live so the frame can be judged on its final cycle.
  assign frame_bits = {~row_s2, frame_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1  <= '1;
      row_s2  <= '1;
      div     <= '0;
      col     <= 2'd0;
      col_out <= 4'b1110;
      frame_q <= '0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      if (step) begin
        div     <= '0;
        col     <= col + 2'd1;
        col_out <= ~(4'b0001 << (col + 2'd1));
        case (col)
          2'd0:    frame_q[3:0]  <= ~row_s2;
          2'd1:    frame_q[7:4]  <= ~row_s2;
          2'd2:    frame_q[11:8] <= ~row_s2;
          default: ;
        endcase
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: debounces whole frames and reports single key presses to the host.
// Report one cycle after the qualifying frame end; valid held until key_ack, overwrite sets overrun.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  input  logic                key_ack,
  output logic                key_down,
  output logic                overrun
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

  logic                         frame_done;
  logic [NUM_ROWS*NUM_COLS-1:0] frame_bits;
  frame_res_t                   res;
  logic [4:0]                   ones;
  logic [3:0]                   hit_idx;
  logic [CODE_W-1:0]            code;
  state_t                       state;
  logic [CODE_W-1:0]            cand;
  logic [CNT_W-1:0]             cnt;
  logic [CNT_W-1:0]             cnt_inc;
  logic                         do_report;

  keypad_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (clk),
    .reset      (reset),
    .row_in     (row_in),
    .col_out    (col_out),
    .frame_done (frame_done),
    .frame_bits (frame_bits)
  );

  always_comb begin
    ones    = '0;
    hit_idx = '0;
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
      if (frame_bits[i]) begin
        ones    = ones + 5'd1;
        hit_idx = 4'(i);
      end
    end
    if (ones == 5'd0)      res = NONE;
    else if (ones == 5'd1) res = SINGLE;
    else                   res = MULTI;
    code    = bit_to_code(hit_idx);
    cnt_inc = cnt + CNT_ONE;
  end

  always_comb begin
    do_report = 1'b0;
    if (frame_done && res == SINGLE) begin
      if (state == IDLE && DEBOUNCE_SCANS == 1)
        do_report = 1'b1;
      if (state == DEB_PRESS && code == cand && cnt_inc == CNT_LAST)
        do_report = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A same-cycle ack consumes the old report, so the new one is not an overrun.
      if (do_report) begin
        key_code  <= code;
        key_valid <= 1'b1;
        overrun   <= key_valid & ~key_ack;
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end

      if (frame_done) begin
        case (state)
          IDLE: begin
            if (res == SINGLE) begin
              cand <= code;
              cnt  <= CNT_ONE;
              if (DEBOUNCE_SCANS == 1) begin
                state    <= PRESSED;
                key_down <= 1'b1;
              end else begin
                state <= DEB_PRESS;
              end
            end
          end
          DEB_PRESS: begin
            if (res == SINGLE && code == cand) begin
              if (cnt_inc == CNT_LAST) begin
                state    <= PRESSED;
                key_down <= 1'b1;
                cnt      <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (res == SINGLE) begin
              cand <= code;
              cnt  <= CNT_ONE;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (res == NONE) begin
              if (DEBOUNCE_SCANS == 1) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end else begin
                state <= DEB_RELEASE;
                cnt   <= CNT_ONE;
              end
            end
          end
          DEB_RELEASE: begin
            if (res == NONE) begin
              if (cnt_inc == CNT_LAST) begin
                state    <= IDLE;
                key_down <= 1'b0;
                cnt      <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle frames).
// A behavioural keypad drives the rows from the column drive and a set of held keys.
module tb_keypad_matrix_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        key_down;
  logic        overrun;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fr = 0;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } rep_t;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    bit          ack;
    int          rep_at;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic        exp_down;
    logic        exp_ovr;
  } step_t;

  rep_t  exp_q[$];
  step_t tbl[$];

  logic       prev_valid = 1'b0;
  logic [3:0] prev_code = '0;

  keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Key k sits at row k/4, column k%4 and pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int k = 0; k < 16; k++)
      if (keys[k] && !col_out[k % 4]) row_in[k / 4] = 1'b0;
  end

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A new report shows as key_valid rising or key_code changing while valid.
  always @(negedge clk) begin
    if (reset && key_valid && (!prev_valid || key_code != prev_code)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_report: got code %0d at cycle %0d expected no report", key_code, cyc);
      end else begin
        rep_t r;
        r = exp_q.pop_front();
        chk("report_code", 32'(key_code), 32'(r.code));
        chk("report_cycle", cyc, r.cyc);
      end
    end
    prev_valid = key_valid;
    prev_code  = key_code;
  end

  task automatic run_step(input logic [15:0] k, input int n, input bit ack,
                          input int rep_at, input logic [3:0] code);
    keys = k;
    if (rep_at > 0) begin
      rep_t r;
      r.code = code;
      r.cyc  = 16 * (fr + rep_at);
      exp_q.push_back(r);
    end
    key_ack = ack;
    for (int i = 0; i < 16 * n; i++) begin
      @(posedge clk);
      #1;
      key_ack = 1'b0;
    end
    fr += n;
  endtask

  function automatic step_t mk(logic [15:0] k, int n, bit a, int r,
                               logic v, logic [3:0] c, logic d, logic o);
    step_t s;
    s.keys = k; s.frames = n; s.ack = a; s.rep_at = r;
    s.exp_valid = v; s.exp_code = c; s.exp_down = d; s.exp_ovr = o;
    return s;
  endfunction

  initial begin
    logic [3:0] exp_col;

    //                 keys      frm ack rep  vld code dn ovr
    tbl.push_back(mk(16'h0200, 5, 0, 2, 1, 4'd9,  1, 0));
    tbl.push_back(mk(16'h0000, 1, 0, 0, 1, 4'd9,  1, 0));
    tbl.push_back(mk(16'h0000, 1, 0, 0, 1, 4'd9,  0, 0));
    tbl.push_back(mk(16'h0000, 1, 1, 0, 0, 4'd9,  0, 0));
    tbl.push_back(mk(16'h0020, 1, 0, 0, 0, 4'd9,  0, 0));
    tbl.push_back(mk(16'h0000, 1, 0, 0, 0, 4'd9,  0, 0));
    tbl.push_back(mk(16'h0020, 1, 0, 0, 0, 4'd9,  0, 0));
    tbl.push_back(mk(16'h0020, 2, 0, 1, 1, 4'd5,  1, 0));
    tbl.push_back(mk(16'h0000, 2, 1, 0, 0, 4'd5,  0, 0));
    tbl.push_back(mk(16'h8001, 4, 0, 0, 0, 4'd5,  0, 0));
    tbl.push_back(mk(16'h0001, 2, 0, 2, 1, 4'd0,  1, 0));
    tbl.push_back(mk(16'h0000, 2, 1, 0, 0, 4'd0,  0, 0));
    tbl.push_back(mk(16'h0008, 2, 0, 2, 1, 4'd3,  1, 0));
    tbl.push_back(mk(16'h0000, 2, 0, 0, 1, 4'd3,  0, 0));
    tbl.push_back(mk(16'h1000, 2, 0, 2, 1, 4'd12, 1, 1));
    tbl.push_back(mk(16'h0000, 2, 0, 0, 1, 4'd12, 0, 1));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_out",   32'(col_out),   32'(4'b1110));
    chk("rst_key_code",  32'(key_code),  0);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_key_down",  32'(key_down),  0);
    chk("rst_overrun",   32'(overrun),   0);
    reset = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      chk($sformatf("idle_col_out_%0d", i), 32'(col_out), 32'(exp_col));
    end
    chk("idle_key_valid", 32'(key_valid), 0);
    fr = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      step_t t;
      t = tbl[i];
      run_step(t.keys, t.frames, t.ack, t.rep_at, t.exp_code);
      chk($sformatf("step%0d_valid", i),   32'(key_valid), 32'(t.exp_valid));
      chk($sformatf("step%0d_code", i),    32'(key_code),  32'(t.exp_code));
      chk($sformatf("step%0d_down", i),    32'(key_down),  32'(t.exp_down));
      chk($sformatf("step%0d_overrun", i), 32'(overrun),   32'(t.exp_ovr));
    end

    // Ack clears valid and overrun on the very next cycle.
    key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;
    chk("ack_valid",   32'(key_valid), 0);
    chk("ack_overrun", 32'(overrun),   0);
    repeat (15) begin @(posedge clk); #1; end
    fr += 1;

    // Ack lands on the exact cycle a new report is registered.
    run_step(16'h0008, 2, 0, 2, 4'd3);
    run_step(16'h0000, 2, 0, 0, 4'd0);
    keys = 16'h1000;
    begin
      rep_t r;
      r.code = 4'd12;
      r.cyc  = 16 * (fr + 2);
      exp_q.push_back(r);
    end
    repeat (31) begin @(posedge clk); #1; end
    key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;
    fr += 2;
    chk("same_cycle_valid",   32'(key_valid), 1);
    chk("same_cycle_code",    32'(key_code),  12);
    chk("same_cycle_overrun", 32'(overrun),   0);

    // Async reset in the middle of debouncing key 7, with a report still pending.
    run_step(16'h0080, 1, 0, 0, 4'd0);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_col_out",   32'(col_out),   32'(4'b1110));
    chk("mid_rst_key_code",  32'(key_code),  0);
    chk("mid_rst_key_valid", 32'(key_valid), 0);
    chk("mid_rst_key_down",  32'(key_down),  0);
    chk("mid_rst_overrun",   32'(overrun),   0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    fr = 0;
    run_step(16'h0080, 3, 0, 2, 4'd7);
    chk("post_rst_valid", 32'(key_valid), 1);
    chk("post_rst_code",  32'(key_code),  7);
    chk("post_rst_down",  32'(key_down),  1);
    run_step(16'h0000, 2, 0, 0, 4'd0);
    chk("post_rst_release_down", 32'(key_down), 0);

    chk("reports_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
